// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, port IDs and constants for the two-port memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int TIMEOUT_DEF = 16;
  localparam logic [31:0] ERR_RDATA = 32'h0;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and memory-side bus of the arbiter
interface mem_arbiter_if;
  logic m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic m0_ready, m1_ready, m0_err, m1_err;
  logic mem_en, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata, mem_ack,
    output m0_rdata, m1_rdata, m0_ready, m1_ready, m0_err, m1_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata, mem_ack,
    input m0_rdata, m1_rdata, m0_ready, m1_ready, m0_err, m1_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; a tie goes to the port not granted last
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);
  assign grant = req0 && req1 ? !last : !req0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of two requesters onto one memory port with ack timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  state_t state, nxt;
  logic [1:0] req_q, ready, err;
  logic last, port, grant, take, done;
  logic [7:0] cnt;
  logic mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, rdata0, rdata1;
  rr_pick2 u_pick (.req0(req_q[0]), .req1(req_q[1]), .last(last), .grant(grant));
  assign take = state == IDLE && |req_q;
  // ack on the last wait cycle still counts as a normal completion
  assign done = state == ACCESS && (bus.mem_ack || cnt == 8'(TIMEOUT - 1));
  always_comb nxt = state == IDLE ? (take ? ACCESS : IDLE) : state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      req_q <= '0;
      last <= PORT1;
      port <= PORT0;
      cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ready <= '0;
      err <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= nxt;
      req_q <= {bus.m1_req, bus.m0_req};
      cnt <= state == ACCESS ? cnt + 8'd1 : '0;
      mem_en <= nxt == ACCESS;
      mem_we <= nxt == ACCESS && (take ? (grant ? bus.m1_we : bus.m0_we) : mem_we);
      if (take) begin
        port <= grant;
        last <= grant;
        mem_addr <= grant ? bus.m1_addr : bus.m0_addr;
        mem_wdata <= grant ? bus.m1_wdata : bus.m0_wdata;
      end
      ready <= {done && port == PORT1, done && port == PORT0};
      err <= {done && !bus.mem_ack && port == PORT1, done && !bus.mem_ack && port == PORT0};
      if (done && port == PORT0) rdata0 <= bus.mem_ack ? bus.mem_rdata : ERR_RDATA;
      if (done && port == PORT1) rdata1 <= bus.mem_ack ? bus.mem_rdata : ERR_RDATA;
    end
  assign bus.mem_en = mem_en;
  assign bus.mem_we = mem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.m0_ready = ready[0];
  assign bus.m1_ready = ready[1];
  assign bus.m0_err = err[0];
  assign bus.m1_err = err[1];
  assign bus.m0_rdata = rdata0;
  assign bus.m1_rdata = rdata1;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of ACCESS cycles to wait for mem_ack before aborting; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-004 m0_req / m1_req  input  1 each  access request from port 0 (CPU fetch/data) and port 1 (DMA/display); held high until the port's ready pulse.
REQ-005 m0_we / m1_we  input  1 each  1 = write, 0 = read; held stable while req is high.
REQ-006 m0_addr / m1_addr  input  32 each  word address; held stable while req is high.
REQ-007 m0_wdata / m1_wdata  input  32 each  write data; held stable while req is high.
REQ-008 m0_rdata / m1_rdata  output  32 each  read data; valid only in the port's ready cycle.
REQ-009 m0_ready / m1_ready  output  1 each  one-cycle completion pulse; m0_ready drives the CPU controller's MIO_ready.
REQ-010 m0_err / m1_err  output  1 each  timeout flag; qualified by the same port's ready.
REQ-011 mem_en  output  1  memory access strobe.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  32  memory address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_rdata  input  32  memory read data; valid with mem_ack.
REQ-016 mem_ack  input  1  memory completion; sampled only while mem_en is high.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP. All outputs are registered.
REQ-018 IDLE: if no request is pending, the FSM stays in IDLE. If any request is pending, it latches the winner's we/addr/wdata and port ID, then moves to ACCESS on the next edge.
REQ-019 Arbitration is round-robin. When both ports request in the same IDLE cycle, the port not granted last wins. A single requester always wins. last_grant updates only on entry to ACCESS.
REQ-020 ACCESS: mem_en = 1 and mem_we/mem_addr/mem_wdata carry the latched values, held constant for the whole ACCESS state.
REQ-021 ACCESS with mem_ack = 1: mem_rdata is captured into the granted port's rdata register (reads and writes alike), err = 0, next state RESP.
REQ-022 ACCESS timeout: a wait counter is cleared on ACCESS entry and increments once per ACCESS cycle. If TIMEOUT cycles elapse without mem_ack, the FSM enters RESP with rdata = 32'h0 and err = 1.
REQ-023 A mem_ack arriving in the same cycle the counter reaches TIMEOUT is treated as a normal completion (ack wins).
REQ-024 RESP: the granted port's ready = 1 for exactly one cycle and mem_en = 0. The other port's ready/err stay 0. Next state is IDLE.
REQ-025 Minimum latency: req sampled high in IDLE at edge k gives mem_en high after edge k+1. With an immediate ack, ready is high after edge k+2, one cycle wide.
REQ-026 A req still high in the IDLE cycle after RESP is a new request. Requesters drop req in the cycle their ready is high.
REQ-027 A request arriving during ACCESS or RESP waits and is never lost. If the non-granted port keeps requesting, it is served next (no starvation).
REQ-028 mem_ack seen outside ACCESS is ignored.
REQ-029 rdata registers hold their last value between ready pulses.

Reset
REQ-030 While reset is asserted, asynchronously: state = IDLE, last_grant = port 1 (so port 0 wins the first tie), wait counter = 0, and all outputs = 0.
REQ-031 Reset during ACCESS or RESP aborts the transaction. No ready pulse is issued for it, and mem_en drops immediately.

Structure
REQ-032 The shared package holds the state encoding (IDLE/ACCESS/RESP), port ID constants PORT0/PORT1, the default TIMEOUT value, and the ERR_RDATA constant 32'h0.
REQ-033 The block is a single module. The round-robin picker may be a combinational sub-module rr_pick2 (inputs req0, req1, last; output grant).

Verification
REQ-034 Single read: m0 reads addr 0x10, mem_ack one cycle after mem_en with rdata 0x12345678 -> m0_ready pulses once with m0_rdata = 0x12345678, m0_err = 0, and m1_ready stays 0.
REQ-035 Tie after reset: m0 and m1 request together -> m0 is served first, then m1. After m1 completes, a repeated tie serves m0, proving alternation.
REQ-036 Write: m1 writes 0xCAFEF00D to 0x40 -> mem_we = 1, mem_addr = 0x40, mem_wdata = 0xCAFEF00D are held until ack, then m1_ready pulses.
REQ-037 Timeout: TIMEOUT = 4, no ack -> mem_en stays high for 4 cycles, then m0_ready = 1, m0_err = 1, m0_rdata = 0.
REQ-038 Ack on the final timeout cycle -> normal completion with err = 0 and the acked data.
REQ-039 Reset asserted mid-ACCESS -> mem_en is 0 immediately, no ready pulse occurs, and after release a tie grants m0.
